seq_game_core: RTL and testbench



---
 rtl/seq_game_core.sv | 186 ++++++++++++++++++
 tb/tb_seq_game_core.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_game_core.sv
// Memory-game sequencer: shows a growing LFSR-generated LED sequence, then checks
// the player's button presses against a replay of that same sequence.
module seq_game_core #(
  parameter int N_CH          = 8,
  parameter int MAX_LEN       = 16,
  parameter int SHOW_TICKS    = 500000,
  parameter int GAP_TICKS     = 200000,
  parameter int TIMEOUT_TICKS = 5000000
) (
  input  logic            clk_2,
  input  logic            rst_n,
  input  logic            start,
  input  logic [15:0]     seed,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] led,
  output logic [7:0]      level,
  output logic [2:0]      phase,
  output logic            busy,
  output logic            win,
  output logic            lose
);

  localparam int CW   = $clog2(N_CH);
  localparam int MAXT = (SHOW_TICKS > GAP_TICKS)
                        ? ((SHOW_TICKS > TIMEOUT_TICKS) ? SHOW_TICKS : TIMEOUT_TICKS)
                        : ((GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS);
  localparam int TW   = $clog2(MAXT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHOW_ON  = 3'd1,
    SHOW_OFF = 3'd2,
    WAIT_IN  = 3'd3,
    WIN      = 3'd4,
    LOSE     = 3'd5
  } state_t;

  state_t          state_q;
  logic [15:0]     seed_q;
  logic [15:0]     lfsr_q;
  logic [TW-1:0]   cnt_q;
  logic [7:0]      idx_q;
  logic [7:0]      level_q;
  logic [N_CH-1:0] led_q;
  logic [N_CH-1:0] btn_prev_q;
  logic            busy_q;
  logic            win_q;
  logic            lose_q;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [N_CH-1:0] item_oh(input logic [15:0] s);
    logic [N_CH-1:0] one;
    one = {{(N_CH-1){1'b0}}, 1'b1};
    return one << s[15 -: CW];
  endfunction

  logic [15:0]     seed_eff;
  logic [15:0]     start_lfsr;
  logic [15:0]     reload_lfsr;
  logic [15:0]     next_lfsr;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] exp_oh;
  logic            idx_last;
  logic            idx_more;

  // The LFSR register always holds the already-stepped value, so its top bits are the current item.
  assign seed_eff    = (seed == 16'h0000) ? 16'hACE1 : seed;
  assign start_lfsr  = lfsr_step(seed_eff);
  assign reload_lfsr = lfsr_step(seed_q);
  assign next_lfsr   = lfsr_step(lfsr_q);
  assign rise        = btn & ~btn_prev_q;
  assign exp_oh      = item_oh(lfsr_q);
  assign idx_last    = ((int'(idx_q) + 1) == int'(level_q));
  assign idx_more    = ((int'(idx_q) + 1) <  int'(level_q));

  always_ff @(posedge clk_2) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      seed_q     <= '0;
      lfsr_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      level_q    <= '0;
      led_q      <= '0;
      btn_prev_q <= '0;
      busy_q     <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      btn_prev_q <= btn;
      if (start) begin
        seed_q  <= seed_eff;
        lfsr_q  <= start_lfsr;
        level_q <= 8'd1;
        idx_q   <= '0;
        cnt_q   <= '0;
        state_q <= SHOW_ON;
        led_q   <= item_oh(start_lfsr);
        busy_q  <= 1'b1;
        win_q   <= 1'b0;
        lose_q  <= 1'b0;
      end else begin
        case (state_q)
          SHOW_ON: begin
            if (cnt_q == TW'(SHOW_TICKS - 1)) begin
              cnt_q   <= '0;
              state_q <= SHOW_OFF;
              led_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          SHOW_OFF: begin
            if (cnt_q == TW'(GAP_TICKS - 1)) begin
              cnt_q <= '0;
              if (idx_more) begin
                idx_q   <= idx_q + 8'd1;
                lfsr_q  <= next_lfsr;
                led_q   <= item_oh(next_lfsr);
                state_q <= SHOW_ON;
              end else begin
                idx_q   <= '0;
                lfsr_q  <= reload_lfsr;
                led_q   <= btn;
                state_q <= WAIT_IN;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          WAIT_IN: begin
            // A press outranks a timeout expiring on the same edge.
            if (rise != '0) begin
              if (rise == exp_oh) begin
                cnt_q <= '0;
                if (idx_last) begin
                  if (level_q == 8'(MAX_LEN)) begin
                    state_q <= WIN;
                    led_q   <= '1;
                    busy_q  <= 1'b0;
                    win_q   <= 1'b1;
                  end else begin
                    level_q <= level_q + 8'd1;
                    idx_q   <= '0;
                    lfsr_q  <= reload_lfsr;
                    led_q   <= item_oh(reload_lfsr);
                    state_q <= SHOW_ON;
                  end
                end else begin
                  idx_q  <= idx_q + 8'd1;
                  lfsr_q <= next_lfsr;
                  led_q  <= btn;
                end
              end else begin
                state_q <= LOSE;
                led_q   <= '0;
                busy_q  <= 1'b0;
                lose_q  <= 1'b1;
              end
            end else if (cnt_q == TW'(TIMEOUT_TICKS - 1)) begin
              state_q <= LOSE;
              led_q   <= '0;
              busy_q  <= 1'b0;
              lose_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              led_q <= btn;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign led   = led_q;
  assign level = level_q;
  assign phase = state_q;
  assign busy  = busy_q;
  assign win   = win_q;
  assign lose  = lose_q;

endmodule

// File: tb/tb_seq_game_core.sv
// Directed-plus-random bench for seq_game_core; expected items come from an
// arithmetic LFSR model and expected phases from the game rules.
module tb_seq_game_core;

  localparam int NC = 4;
  localparam int ML = 3;
  localparam int ST = 4;
  localparam int GT = 2;
  localparam int TT = 20;

  logic          clk_2 = 1'b0;
  logic          rst_n;
  logic          start;
  logic [15:0]   seed;
  logic [NC-1:0] btn;
  logic [NC-1:0] led;
  logic [7:0]    level;
  logic [2:0]    phase;
  logic          busy;
  logic          win;
  logic          lose;

  int total = 0;
  int bad   = 0;
  int items [ML];

  seq_game_core #(
    .N_CH(NC), .MAX_LEN(ML), .SHOW_TICKS(ST), .GAP_TICKS(GT), .TIMEOUT_TICKS(TT)
  ) dut (
    .clk_2(clk_2), .rst_n(rst_n), .start(start), .seed(seed), .btn(btn),
    .led(led), .level(level), .phase(phase), .busy(busy), .win(win), .lose(lose)
  );

  always #5 clk_2 = ~clk_2;

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [NC-1:0] oh(input int b);
    return NC'(1) << b;
  endfunction

  task automatic make_items(input logic [15:0] sd);
    logic [15:0] s;
    s = (sd == 16'h0000) ? 16'hACE1 : sd;
    for (int k = 0; k < ML; k++) begin
      s = lstep(s);
      items[k] = int'(s[15:14]);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] sd);
    seed = sd;
    make_items(sd);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called right after the edge that entered SHOW_ON; ends on the first WAIT_IN cycle.
  task automatic show_round(input int lv);
    for (int i = 0; i < lv; i++) begin
      for (int c = 0; c < ST; c++) begin
        chk("show_on_phase", 32'(phase), 32'd1);
        chk("show_on_led", 32'(led), 32'(oh(items[i])));
        chk("show_busy", 32'(busy), 32'd1);
        tick();
      end
      for (int c = 0; c < GT; c++) begin
        chk("show_off_phase", 32'(phase), 32'd2);
        chk("show_off_led", 32'(led), 32'd0);
        tick();
      end
    end
    chk("wait_phase", 32'(phase), 32'd3);
    chk("wait_level", 32'(level), 32'(lv));
    chk("wait_busy", 32'(busy), 32'd1);
  endtask

  task automatic play_round(input int lv);
    for (int j = 0; j < lv; j++) begin
      if (j > 0) tick();
      btn = oh(items[j]);
      tick();
      btn = '0;
      if (j < lv - 1) begin
        chk("press_phase", 32'(phase), 32'd3);
        chk("press_mirror", 32'(led), 32'(oh(items[j])));
      end else if (lv == ML) begin
        chk("win_phase", 32'(phase), 32'd4);
        chk("win_flag", 32'(win), 32'd1);
        chk("win_led", 32'(led), 32'hF);
        chk("win_level", 32'(level), 32'(ML));
        chk("win_busy", 32'(busy), 32'd0);
      end else begin
        chk("next_phase", 32'(phase), 32'd1);
        chk("next_level", 32'(level), 32'(lv + 1));
        chk("next_led", 32'(led), 32'(oh(items[0])));
      end
    end
  endtask

  task automatic chk_lose(input int lv);
    chk("lose_phase", 32'(phase), 32'd5);
    chk("lose_flag", 32'(lose), 32'd1);
    chk("lose_win", 32'(win), 32'd0);
    chk("lose_busy", 32'(busy), 32'd0);
    chk("lose_led", 32'(led), 32'd0);
    chk("lose_level", 32'(level), 32'(lv));
  endtask

  task automatic chk_idle();
    chk("idle_phase", 32'(phase), 32'd0);
    chk("idle_led", 32'(led), 32'd0);
    chk("idle_level", 32'(level), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_win", 32'(win), 32'd0);
    chk("idle_lose", 32'(lose), 32'd0);
  endtask

  task automatic full_game(input logic [15:0] sd);
    do_start(sd);
    for (int lv = 1; lv <= ML; lv++) begin
      show_round(lv);
      play_round(lv);
    end
    for (int c = 0; c < 3; c++) begin
      btn = NC'($urandom_range(15, 0));
      tick();
      chk("win_hold", 32'(phase), 32'd4);
      chk("win_hold_led", 32'(led), 32'hF);
    end
    btn = '0;
  endtask

  initial begin
    int          wrong;
    logic [15:0] rs;

    rst_n = 1'b0;
    start = 1'b1;
    seed  = 16'h1234;
    btn   = '0;
    tick();
    tick();
    chk_idle();
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk_idle();

    // Correct play to WIN, fixed seed then random seed.
    full_game(16'hACE1);
    rs = 16'($urandom_range(65535, 1));
    full_game(rs);

    // Wrong single button in round 1.
    do_start(16'($urandom_range(65535, 0)));
    show_round(1);
    wrong = (items[0] + 1 + int'($urandom_range(2, 0))) % NC;
    btn = oh(wrong);
    tick();
    btn = '0;
    chk_lose(1);
    btn = NC'($urandom_range(15, 0));
    tick();
    tick();
    btn = '0;
    chk_lose(1);

    // Two bits rising together, one of them correct.
    do_start(16'hACE1);
    show_round(1);
    btn = 4'b1001;
    tick();
    btn = '0;
    chk_lose(1);

    // Timeout with no press.
    do_start(16'($urandom_range(65535, 0)));
    show_round(1);
    for (int c = 0; c < TT - 1; c++) begin
      tick();
      chk("timeout_wait", 32'(phase), 32'd3);
    end
    tick();
    chk_lose(1);

    // Press on the final timeout cycle wins over the timeout; counter restarts after a press.
    do_start(16'($urandom_range(65535, 0)));
    show_round(1);
    for (int c = 0; c < TT - 1; c++) tick();
    btn = oh(items[0]);
    tick();
    btn = '0;
    chk("late_press_phase", 32'(phase), 32'd1);
    chk("late_press_level", 32'(level), 32'd2);
    show_round(2);
    btn = oh(items[0]);
    tick();
    btn = '0;
    chk("r2_first_press", 32'(phase), 32'd3);
    for (int c = 0; c < TT - 1; c++) tick();
    chk("r2_before_late", 32'(phase), 32'd3);
    btn = oh(items[1]);
    tick();
    btn = '0;
    chk("r2_late_phase", 32'(phase), 32'd1);
    chk("r2_late_level", 32'(level), 32'd3);
    show_round(3);
    for (int c = 0; c < TT - 1; c++) tick();
    chk("r3_wait", 32'(phase), 32'd3);
    tick();
    chk_lose(3);

    // Reset during SHOW_ON, then seed 0 replays the default seed.
    do_start(16'($urandom_range(65535, 1)));
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk_idle();
    rst_n = 1'b1;
    tick();
    chk_idle();
    do_start(16'h0000);
    show_round(1);
    play_round(1);

    // Button held across entry to WAIT_IN does not count.
    do_start(16'hACE1);
    btn = oh(items[0]);
    show_round(1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("held_phase", 32'(phase), 32'd3);
      chk("held_level", 32'(level), 32'd1);
      chk("held_mirror", 32'(led), 32'(oh(items[0])));
    end
    btn = '0;
    tick();
    chk("release_phase", 32'(phase), 32'd3);
    btn = oh(items[0]);
    tick();
    btn = '0;
    chk("repress_phase", 32'(phase), 32'd1);
    chk("repress_level", 32'(level), 32'd2);

    // start coinciding with a wrong press restarts the game.
    do_start(16'($urandom_range(65535, 0)));
    show_round(1);
    btn = oh((items[0] + 1) % NC);
    seed = 16'($urandom_range(65535, 0));
    make_items(seed);
    start = 1'b1;
    tick();
    start = 1'b0;
    btn = '0;
    chk("restart_phase", 32'(phase), 32'd1);
    chk("restart_level", 32'(level), 32'd1);
    chk("restart_lose", 32'(lose), 32'd0);
    chk("restart_led", 32'(led), 32'(oh(items[0])));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
